// File: rtl/fpmul_ieee_seq.sv
`timescale 1ns/1ps
// fpmul_ieee_seq: parametrised IEEE-754 multiplier with a shift-add significand
// datapath (one bit per cycle), RNE rounding, FTZ inputs and no subnormal outputs.
module fpmul_ieee_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   St,
    input  logic [EXP_W+MAN_W:0]   FPmplier,
    input  logic [EXP_W+MAN_W:0]   FPmcand,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Ovf,
    output logic                   Unf,
    output logic                   Inv,
    output logic [EXP_W+MAN_W:0]   FPproduct
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MAN_W + 1);

    localparam logic [EXP_W-1:0]     EMAX     = '1;
    localparam logic signed [EW-1:0] BIAS_E   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_E   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_E   = '0;
    localparam logic [CW-1:0]        CNT_LAST = CW'(MAN_W);

    typedef enum logic [2:0] {IDLE, UNPACK, MULT, ROUND, OUT} state_t;

    state_t               state_q;
    logic [W-1:0]         opa_q, opb_q, prod_q;
    logic [SW-1:0]        mb_q;
    logic [PW-1:0]        acc_q;
    logic [CW-1:0]        cnt_q;
    logic signed [EW-1:0] e_q;
    logic                 sign_q, nan_q, inf_q, zero_q;
    logic                 busy_q, done_q, ovf_q, unf_q, inv_q;

    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 za, zb, ia, ib, na, nb;
    logic signed [EW-1:0] e_d;
    logic [SW:0]          sum;

    assign ea = opa_q[W-2 -: EXP_W];
    assign eb = opb_q[W-2 -: EXP_W];
    assign fa = opa_q[MAN_W-1:0];
    assign fb = opb_q[MAN_W-1:0];
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (ea == EMAX) && (fa == '0);
    assign ib = (eb == EMAX) && (fb == '0);
    assign na = (ea == EMAX) && (fa != '0);
    assign nb = (eb == EMAX) && (fb != '0);
    assign e_d = EW'(ea) + EW'(eb) - BIAS_E;

    // acc = {partial sum, remaining multiplier bits}; shifts right each step
    assign sum = {1'b0, acc_q[PW-1:SW]} + (acc_q[0] ? {1'b0, mb_q} : '0);

    logic                 norm, guard, sticky, rnd, carry;
    logic [MAN_W-1:0]     frac_t, frac_r;
    logic signed [EW-1:0] e_r;
    logic [W-1:0]         res_d;
    logic                 ovf_d, unf_d, inv_d;

    always_comb begin
        norm   = acc_q[PW-1];
        frac_t = norm ? acc_q[PW-2 -: MAN_W] : acc_q[PW-3 -: MAN_W];
        guard  = norm ? acc_q[MAN_W] : acc_q[MAN_W-1];
        sticky = norm ? |acc_q[MAN_W-1:0] : |acc_q[MAN_W-2:0];
        rnd    = guard & (sticky | frac_t[0]);
        {carry, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd};
        e_r    = e_q + EW'(norm) + EW'(carry);
        res_d  = {sign_q, {(W-1){1'b0}}};
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        inv_d  = 1'b0;
        if (nan_q) begin
            res_d = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
            inv_d = 1'b1;
        end else if (inf_q) begin
            res_d = {sign_q, EMAX, {MAN_W{1'b0}}};
        end else if (zero_q) begin
            res_d = {sign_q, {(W-1){1'b0}}};
        end else if (e_r >= EMAX_E) begin
            res_d = {sign_q, EMAX, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (e_r <= ZERO_E) begin
            unf_d = 1'b1;
        end else begin
            res_d = {sign_q, e_r[EXP_W-1:0], frac_r};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            prod_q  <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            e_q     <= '0;
            sign_q  <= 1'b0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (St) begin
                        opa_q   <= FPmplier;
                        opb_q   <= FPmcand;
                        busy_q  <= 1'b1;
                        state_q <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q  <= opa_q[W-1] ^ opb_q[W-1];
                    nan_q   <= na | nb | (ia & zb) | (za & ib);
                    inf_q   <= ia | ib;
                    zero_q  <= za | zb;
                    mb_q    <= {1'b1, fb};
                    acc_q   <= {{SW{1'b0}}, 1'b1, fa};
                    e_q     <= e_d;
                    cnt_q   <= '0;
                    state_q <= MULT;
                end
                MULT: begin
                    acc_q <= {sum, acc_q[SW-1:1]};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_q <= ROUND;
                end
                ROUND: begin
                    prod_q  <= res_d;
                    ovf_q   <= ovf_d;
                    unf_q   <= unf_d;
                    inv_q   <= inv_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= OUT;
                end
                OUT: begin
                    done_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                    unf_q   <= 1'b0;
                    inv_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Ovf       = ovf_q;
    assign Unf       = unf_q;
    assign Inv       = inv_q;
    assign FPproduct = prod_q;
endmodule

// File: tb/tb_fpmul_ieee_seq.sv
`timescale 1ns/1ps
// Bench for fpmul_ieee_seq in single-precision format: integer reference model,
// latency/handshake/reset scenarios and randomized operands.
module tb_fpmul_ieee_seq;
    logic        Clk = 1'b0;
    logic        Rst_n, St;
    logic [31:0] FPmplier, FPmcand, FPproduct;
    logic        Busy, Done, Ovf, Unf, Inv;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [34:0] exp_q[$];
    logic [34:0] mon_exp;

    logic [31:0] da[13];
    logic [31:0] db[13];
    logic [31:0] dr[13];
    logic [2:0]  df[13];

    always #5 Clk = ~Clk;

    fpmul_ieee_seq dut (
        .Clk(Clk), .Rst_n(Rst_n), .St(St),
        .FPmplier(FPmplier), .FPmcand(FPmcand),
        .Busy(Busy), .Done(Done), .Ovf(Ovf), .Unf(Unf), .Inv(Inv),
        .FPproduct(FPproduct)
    );

    // Returns {Inv, Ovf, Unf, product} from exact integer arithmetic.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        bit s  = a[31] ^ b[31];
        bit za = (ea == 0);
        bit zb = (eb == 0);
        bit ia = (ea == 255) && (a[22:0] == 0);
        bit ib = (eb == 255) && (b[22:0] == 0);
        bit na = (ea == 255) && (a[22:0] != 0);
        bit nb = (eb == 255) && (b[22:0] != 0);
        longint unsigned p, q, rem, half;
        int e, sh;
        if (na || nb || (ia && zb) || (za && ib)) return {3'b100, 32'h7FC00000};
        if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
        if (za || zb) return {3'b000, s, 31'h0};
        p  = (64'(a[22:0]) | 64'h800000) * (64'(b[22:0]) | 64'h800000);
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b001, s, 31'h0};
        return {3'b000, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int k;
        k = int'($urandom_range(0, 9));
        case (k)
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'($urandom_range(1, 8));
            3:       e = 8'($urandom_range(180, 254));
            4, 5:    e = 8'($urandom_range(110, 145));
            default: e = 8'($urandom_range(1, 254));
        endcase
        k = int'($urandom_range(0, 5));
        case (k)
            0:       f = '0;
            1:       f = 23'($urandom) & 23'h7FF000;
            2:       f = '1;
            default: f = 23'($urandom);
        endcase
        return {1'($urandom), e, f};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Rst_n && Done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_done: got %h want no result", FPproduct);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({Inv, Ovf, Unf, FPproduct} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL result: got %h want %h",
                             {Inv, Ovf, Unf, FPproduct}, mon_exp);
                end
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
        int          lat;
        bit          busy_ok;
        logic [34:0] e;
        e = model(a, b);
        @(negedge Clk);
        St = 1'b1; FPmplier = a; FPmcand = b;
        exp_q.push_back(e);
        @(negedge Clk);
        St = 1'b0; FPmplier = $urandom; FPmcand = $urandom;
        lat = -1;
        busy_ok = 1'b1;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            if (n > 0) @(negedge Clk);
            if (poke) begin
                St = (n == 4);
                FPmplier = $urandom;
                FPmcand = $urandom;
            end
            if (Done) lat = n;
            else if (Busy !== 1'b1) busy_ok = 1'b0;
        end
        check("done_latency", lat, 26);
        check("busy_window", busy_ok, 1);
        check("busy_at_done", Busy, 0);
        @(negedge Clk);
        check("after_done", {Done, Inv, Ovf, Unf, FPproduct}, {4'b0, e[31:0]});
    endtask

    task automatic back_to_back();
        logic [31:0] a, b, c, d;
        int d1, d2;
        a = rnd_fp(); b = rnd_fp(); c = rnd_fp(); d = rnd_fp();
        d1 = -1; d2 = -1;
        @(negedge Clk);
        St = 1'b1; FPmplier = a; FPmcand = b;
        exp_q.push_back(model(a, b));
        @(negedge Clk);
        FPmplier = c; FPmcand = d;
        exp_q.push_back(model(c, d));
        for (int n = 0; n < 80 && d2 < 0; n++) begin
            if (n > 0) @(negedge Clk);
            if (Done) begin
                if (d1 < 0) d1 = n;
                else d2 = n;
            end
        end
        St = 1'b0;
        check("b2b_first_latency", d1, 26);
        // 27 non-Done cycles lie strictly between the two pulses
        check("b2b_done_spacing", d2 - d1, 28);
        @(negedge Clk);
    endtask

    task automatic reset_abort();
        bit seen;
        @(negedge Clk);
        St = 1'b1; FPmplier = 32'h40490FDB; FPmcand = 32'h402DF854;
        exp_q.push_back(model(FPmplier, FPmcand));
        @(negedge Clk);
        St = 1'b0;
        repeat (9) @(negedge Clk);
        Rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_state", {Busy, Done, Inv, Ovf, Unf, FPproduct}, 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge Clk);
            if (Done) seen = 1'b1;
        end
        check("no_done_after_abort", seen, 0);
        run_op(32'h3F800000, 32'h3F800000, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        da = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h3F800001, 32'h7F000000,
               32'h00800000, 32'h80400000, 32'h7F800000, 32'h7FC00001, 32'hFF800000,
               32'h3F800001, 32'h3F800003, 32'h3F800000};
        db = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h3F7FFFFF, 32'h7F000000,
               32'h00800000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h40000000,
               32'h3FC00000, 32'h3FC00000, 32'h3F800000};
        dr = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h3F800000, 32'h7F800000,
               32'h00000000, 32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
               32'h3FC00002, 32'h3FC00004, 32'h3F800000};
        df = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010,
               3'b001, 3'b000, 3'b100, 3'b100, 3'b000,
               3'b000, 3'b000, 3'b000};

        Rst_n = 1'b0; St = 1'b0; FPmplier = '0; FPmcand = '0;
        #1;
        check("reset_state", {Busy, Done, Inv, Ovf, Unf, FPproduct}, 0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            check("model_pin", model(da[i], db[i]), {df[i], dr[i]});
        for (int i = 0; i < 13; i++)
            run_op(da[i], db[i], 1'b0);

        run_op(32'h3FC00000, 32'h40000000, 1'b1);
        reset_abort();
        back_to_back();
        repeat (40) run_op(rnd_fp(), rnd_fp(), 1'b0);

        repeat (3) @(negedge Clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
